// File: rtl/cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiply with low-word and signed/unsigned high-word modes.
// Result valid LATENCY cycles after an accepted start; A_mul_stall freezes every stage and the output.
module cpu_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  input  logic [1:0]        A_mul_mode,
  input  logic              A_mul_start,
  input  logic              A_mul_stall,
  output logic [DATA_W-1:0] A_mul_cell_result,
  output logic              A_mul_result_valid,
  output logic              A_mul_busy
);
  localparam int H   = DATA_W / 2;
  localparam int PPW = 2 * H + 2;
  localparam int PW  = 2 * DATA_W;

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULXSS = 2'd1;
  localparam logic [1:0] MODE_MULXSU = 2'd2;

  logic                  accept;
  logic                  src1_sext;
  logic                  src2_sext;
  logic [H-1:0]          a_lo;
  logic [H-1:0]          b_lo;
  logic [H:0]            a_hi;
  logic [H:0]            b_hi;
  logic signed [PPW-1:0] a_lo_x;
  logic signed [PPW-1:0] a_hi_x;
  logic signed [PPW-1:0] b_lo_x;
  logic signed [PPW-1:0] b_hi_x;
  logic signed [PPW-1:0] pp_ll_c;
  logic signed [PPW-1:0] pp_lh_c;
  logic signed [PPW-1:0] pp_hl_c;
  logic signed [PPW-1:0] pp_hh_c;
  logic [DATA_W-1:0]     tail_word;
  logic                  tail_vld;
  logic                  pipe_busy;

  function automatic logic [PW-1:0] sx(input logic [PPW-1:0] v);
    return {{(PW-PPW){v[PPW-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] pp_word(input logic [PPW-1:0] ll, input logic [PPW-1:0] lh,
                                                 input logic [PPW-1:0] hl, input logic [PPW-1:0] hh,
                                                 input logic [1:0] mode);
    logic [PW-1:0] prod;
    prod = sx(ll) + ((sx(lh) + sx(hl)) << H) + (sx(hh) << DATA_W);
    return (mode == MODE_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
  endfunction

  assign accept    = A_mul_start & ~A_mul_stall;
  assign src1_sext = (A_mul_mode == MODE_MULXSS) || (A_mul_mode == MODE_MULXSU);
  assign src2_sext = (A_mul_mode == MODE_MULXSS);

  // Upper halves carry the (DATA_W+1)-th extension bit, so they are H+1 bits signed.
  assign a_lo   = A_mul_src1[H-1:0];
  assign b_lo   = A_mul_src2[H-1:0];
  assign a_hi   = {src1_sext & A_mul_src1[DATA_W-1], A_mul_src1[DATA_W-1:H]};
  assign b_hi   = {src2_sext & A_mul_src2[DATA_W-1], A_mul_src2[DATA_W-1:H]};
  assign a_lo_x = {{(PPW-H){1'b0}}, a_lo};
  assign b_lo_x = {{(PPW-H){1'b0}}, b_lo};
  assign a_hi_x = {{(PPW-H-1){a_hi[H]}}, a_hi};
  assign b_hi_x = {{(PPW-H-1){b_hi[H]}}, b_hi};

  assign pp_ll_c = a_lo_x * b_lo_x;
  assign pp_lh_c = a_lo_x * b_hi_x;
  assign pp_hl_c = a_hi_x * b_lo_x;
  assign pp_hh_c = a_hi_x * b_hi_x;

  generate
    if (LATENCY == 1) begin : g_comb
      assign tail_word = pp_word(pp_ll_c, pp_lh_c, pp_hl_c, pp_hh_c, A_mul_mode);
      assign tail_vld  = accept;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [PPW-1:0]    pp_ll_q;
      logic [PPW-1:0]    pp_lh_q;
      logic [PPW-1:0]    pp_hl_q;
      logic [PPW-1:0]    pp_hh_q;
      logic [1:0]        mode_q;
      logic              s1_vld;
      logic [DATA_W-1:0] s2_word;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pp_ll_q <= '0;
          pp_lh_q <= '0;
          pp_hl_q <= '0;
          pp_hh_q <= '0;
          mode_q  <= MODE_MUL;
          s1_vld  <= 1'b0;
        end else if (!A_mul_stall) begin
          pp_ll_q <= pp_ll_c;
          pp_lh_q <= pp_lh_c;
          pp_hl_q <= pp_hl_c;
          pp_hh_q <= pp_hh_c;
          mode_q  <= A_mul_mode;
          s1_vld  <= accept;
        end
      end

      assign s2_word = pp_word(pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q, mode_q);

      if (LATENCY == 2) begin : g_direct
        assign tail_word = s2_word;
        assign tail_vld  = s1_vld;
        assign pipe_busy = s1_vld;
      end else begin : g_retime
        localparam int ND = LATENCY - 2;
        logic [DATA_W-1:0] dly_word [ND];
        logic [ND-1:0]     dly_vld;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int i = 0; i < ND; i++) dly_word[i] <= '0;
            dly_vld <= '0;
          end else if (!A_mul_stall) begin
            dly_word[0] <= s2_word;
            dly_vld[0]  <= s1_vld;
            for (int i = 1; i < ND; i++) begin
              dly_word[i] <= dly_word[i-1];
              dly_vld[i]  <= dly_vld[i-1];
            end
          end
        end

        assign tail_word = dly_word[ND-1];
        assign tail_vld  = dly_vld[ND-1];
        assign pipe_busy = s1_vld | (|dly_vld);
      end
    end
  endgenerate

  // The output word only moves on a valid result so it holds across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A_mul_cell_result  <= '0;
      A_mul_result_valid <= 1'b0;
    end else if (!A_mul_stall) begin
      A_mul_result_valid <= tail_vld;
      if (tail_vld) A_mul_cell_result <= tail_word;
    end
  end

  assign A_mul_busy = pipe_busy | A_mul_result_valid;

endmodule

// File: doc/cpu_mult_pipe.md
# cpu_mult_pipe

Parametrised, pipelined integer multiply unit for the soft CPU's A-stage multiply path. It generalises the fixed 32-bit, low-word-only multiply cell to any even DATA_W and a configurable pipeline depth. It adds high-word modes (signed×signed, signed×unsigned, unsigned×unsigned), a start/valid handshake and a pipeline stall. It accepts one operation per cycle and returns results in issue order.

## Interface
- DATA_W, 32, operand and result width; even, 16..64
- LATENCY, 2, cycles from accepted start to result_valid; 1..4

- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- A_mul_src1  in  DATA_W  operand 1
- A_mul_src2  in  DATA_W  operand 2
- A_mul_mode  in  2  0=MUL (low word), 1=MULXSS, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXUU (high word)
- A_mul_start  in  1  operands/mode valid this cycle
- A_mul_stall  in  1  freeze entire pipeline
- A_mul_cell_result  out  DATA_W  selected product word
- A_mul_result_valid  out  1  result present this cycle
- A_mul_busy  out  1  at least one operation in flight

## Operation
- Clock and reset are fixed: one clock, `clk`; asynchronous active-low reset, `reset_n`.
- Product is computed as the full 2·DATA_W result of (DATA_W+1)×(DATA_W+1) signed multiply.
  - Operand extension: src1 is sign-extended for modes 1 and 2, zero-extended otherwise. src2 is sign-extended for mode 1, zero-extended otherwise.
- Result select:
  - mode 0: product[DATA_W-1:0]. Identical for signed and unsigned interpretation.
  - modes 1–3: product[2·DATA_W-1:DATA_W].
- Implementation splits operands into DATA_W/2 halves and forms four partial products. Partial-product registers sit in stage 1. Addition and word select are spread over the remaining LATENCY-1 stages, or are combinational into the output register when LATENCY=1.
- Each stage carries a valid bit and the mode tag.
- Accept: start sampled on a rising edge only when A_mul_stall=0. A start asserted while stall=1 is ignored; the issuer must hold it.
- Stall=1: every stage register, valid bit and output register holds its value, including A_mul_cell_result and A_mul_result_valid.
- A_mul_busy = OR of all stage valid bits and the output valid bit.
- Empty bubbles propagate with valid=0. The data registers of invalid stages may update, but A_mul_cell_result holds its last valid value when no new result arrives.

## Timing
- Reset (async assert, any cycle, including mid-operation):
  - All valid bits go to 0 immediately.
  - A_mul_cell_result = 0, A_mul_result_valid = 0, A_mul_busy = 0.
  - In-flight operations are discarded.
- Release: the first start is accepted on the first rising edge with reset_n=1.
- Latency: start accepted at edge N gives result_valid=1 and the result during the cycle after edge N+LATENCY-1. This is LATENCY edges counting edge N as the first, with no stalls in between.
  - Each stalled cycle adds exactly one cycle.
- Throughput: one op per unstalled cycle. Back-to-back starts yield back-to-back valid pulses in order.
- result_valid is a one-cycle pulse per op when unstalled. Under stall it is held high, and the same op is presented until stall drops.
- Start and stall asserted together: the start is not accepted; the pipeline holds.
- No wrap or overflow flag. The high/low word is taken modulo 2^DATA_W as defined above.

## Test plan
- Mode check, DATA_W=32: src1=0x00010003, src2=0x00020005.
  - mode 0 -> result 0x000B000F.
  - mode 3 -> result 0x00000002.
  - Each result arrives with valid exactly LATENCY cycles after start, for LATENCY=1,2,4.
- Sign modes: src1=src2=0xFFFFFFFF.
  - mode 1 -> 0x00000000.
  - mode 2 -> 0xFFFFFFFF.
  - mode 3 -> 0xFFFFFFFE.
  - mode 0 -> 0x00000001.
- Corner: 0x80000000×0x80000000.
  - mode 1 -> 0x40000000.
  - mode 0 -> 0x00000000.
  - mode 2 -> 0xC0000000.
- Back-to-back, LATENCY=2: starts on 3 consecutive edges (2×3, 4×5, 6×7, mode 0).
  - valid on 3 consecutive cycles with 6, 20, 42.
  - busy falls the cycle after the last valid.
- Stall: issue 2 ops, assert stall for 3 cycles once the first result is valid.
  - result and valid are held for all 3 cycles.
  - Second result follows one cycle after stall drops.
  - A start pulsed during the stall produces no result.
- Reset mid-flight: issue 2 ops, pulse reset_n low between edges.
  - Outputs are 0 asynchronously.
  - No valid pulses appear afterwards.
  - A new op issued after release returns the correct result at nominal latency.
- Random: 10k random operand/mode/start/stall at DATA_W=16, 32 and 64 versus a reference model; compare every valid result in order.
